cmd_dispatcher: RTL

//  Parametrised successor issuer: pops commands (id, dep, info) from the CPU queue, tracks running cmd per proc,

---
 rtl/issuer_pkg.sv | 48 ++++
 rtl/dep_park_table.sv | 74 +++++++
 rtl/cmd_dispatcher.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/issuer_pkg.sv
// Shared types for the command dispatcher: command/instruction formats, FSM states and priority helper.
package issuer_pkg;

    localparam int ID_W = 8;

    typedef logic [ID_W-1:0] cmd_id_t;

    localparam cmd_id_t ID_NONE = '0;

    typedef struct packed {
        logic [15:0] addr_0;
        logic [15:0] addr_1;
        logic [15:0] wr_addr;
        logic [7:0]  count;
        logic [3:0]  op;
    } cmd_info_t;

    typedef struct packed {
        cmd_id_t   id;
        cmd_id_t   dep;
        cmd_info_t info;
    } cmd_t;

    typedef logic [1:0] opcode_t;

    localparam opcode_t INSTR_LD    = 2'd1;
    localparam opcode_t INSTR_INFO  = 2'd2;
    localparam opcode_t INSTR_STORE = 2'd3;

    typedef struct packed {
        opcode_t     opcode;
        logic [15:0] payload;
    } instr_t;

    typedef enum logic [3:0] {
        IDLE, CHECK, PARK, SEL, LD0, LD1, INFO, STORE, FINISH
    } state_t;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic int unsigned find_first_set_bit(input logic [31:0] vec);
        int unsigned idx = 0;
        for (int i = 31; i >= 0; i--) begin
            if (vec[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/dep_park_table.sv
// Park table for dependent commands: stores entries, flags which can wake, and reports free slot/count.
module dep_park_table
    import issuer_pkg::*;
#(
    parameter int PARK_DEPTH = 8,
    parameter int PROC_COUNT = 4,
    parameter int PARK_W     = $clog2(PARK_DEPTH),
    parameter int CNT_W      = $clog2(PARK_DEPTH + 1)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_wr_en,
    input  logic [PARK_W-1:0]       i_wr_idx,
    input  cmd_t                    i_wr_cmd,
    input  logic                    i_rd_en,
    input  logic [PARK_W-1:0]       i_rd_idx,
    output cmd_t                    o_rd_cmd,
    input  logic [PROC_COUNT-1:0]   i_run_valid,
    input  cmd_id_t [PROC_COUNT-1:0] i_run_id,
    input  cmd_id_t                 i_query_dep,
    output logic                    o_query_pending,
    output logic                    o_wake_hit,
    output logic [PARK_W-1:0]       o_wake_idx,
    output logic [PARK_W-1:0]       o_free_idx,
    output logic [CNT_W-1:0]        o_count
);

    logic [PARK_DEPTH-1:0] ent_valid;
    cmd_t                  ent_cmd [PARK_DEPTH];
    logic [PARK_DEPTH-1:0] wakeable;
    logic [PARK_DEPTH-1:0] free_vec;

    // A dep is outstanding while it is running on a proc or still parked itself.
    function automatic logic dep_pending(input cmd_id_t dep);
        logic hit = 1'b0;
        for (int p = 0; p < PROC_COUNT; p++) begin
            if (i_run_valid[p] && i_run_id[p] == dep) hit = 1'b1;
        end
        for (int e = 0; e < PARK_DEPTH; e++) begin
            if (ent_valid[e] && ent_cmd[e].id == dep) hit = 1'b1;
        end
        return (dep != ID_NONE) && hit;
    endfunction

    always_comb begin
        wakeable = '0;
        o_count  = '0;
        for (int e = 0; e < PARK_DEPTH; e++) begin
            wakeable[e] = ent_valid[e] && !dep_pending(ent_cmd[e].dep);
            o_count     = o_count + CNT_W'(ent_valid[e]);
        end
    end

    assign free_vec        = ~ent_valid;
    assign o_wake_hit      = |wakeable;
    assign o_wake_idx      = PARK_W'(find_first_set_bit(32'(wakeable)));
    assign o_free_idx      = PARK_W'(find_first_set_bit(32'(free_vec)));
    assign o_query_pending = dep_pending(i_query_dep);
    assign o_rd_cmd        = ent_cmd[i_rd_idx];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ent_valid <= '0;
        end else begin
            if (i_rd_en) ent_valid[i_rd_idx] <= 1'b0;
            if (i_wr_en) ent_valid[i_wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_wr_en) ent_cmd[i_wr_idx] <= i_wr_cmd;
    end

endmodule

// File: rtl/cmd_dispatcher.sv
// Issues queued commands to free SIMD procs as 4-beat instruction streams, parking dependent commands.
// Define ISSUER_PERF_EN to add saturating issue/park/stall counters.
//  state  | meaning
//  IDLE   | arbitrate finish > wake > new cmd
//  CHECK  | test captured cmd for an outstanding dep
//  PARK   | store dependent cmd in the park table
//  SEL    | enable lowest free proc, mark it running
//  LD0..STORE | stream the four instruction beats
//  FINISH | ack the finished proc, retire its cmd
module cmd_dispatcher
    import issuer_pkg::*;
#(
    parameter int PROC_COUNT = 4,
    parameter int PARK_DEPTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  cmd_t                  i_cmd,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic [PROC_COUNT-1:0] i_busy_proc,
    input  logic [PROC_COUNT-1:0] i_finish_proc,
    output logic [PROC_COUNT-1:0] o_en_proc,
    output logic [PROC_COUNT-1:0] o_ack_proc,
    output instr_t                o_instr,
    output logic                  o_idle,
    output logic                  o_err_spurious
`ifdef ISSUER_PERF_EN
    ,
    output logic [31:0]           o_perf_issued,
    output logic [31:0]           o_perf_parked,
    output logic [31:0]           o_perf_stall
`endif
);

    localparam int PROC_W = $clog2(PROC_COUNT);
    localparam int PARK_W = $clog2(PARK_DEPTH);
    localparam int CNT_W  = $clog2(PARK_DEPTH + 1);

    state_t                  state, state_d;
    cmd_t                    cmd_q, wake_cmd;
    logic [PROC_W-1:0]       proc_q, fin_q, free_p, fin_p;
    logic [PROC_COUNT-1:0]   run_valid, free_vec;
    cmd_id_t [PROC_COUNT-1:0] run_id;
    logic                    any_free, fin_any;
    logic                    park_wr, park_rd, query_pending, wake_hit;
    logic [PARK_W-1:0]       wake_idx, free_idx;
    logic [CNT_W-1:0]        park_count;

    dep_park_table #(
        .PARK_DEPTH (PARK_DEPTH),
        .PROC_COUNT (PROC_COUNT)
    ) u_park (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_wr_en         (park_wr),
        .i_wr_idx        (free_idx),
        .i_wr_cmd        (cmd_q),
        .i_rd_en         (park_rd),
        .i_rd_idx        (wake_idx),
        .o_rd_cmd        (wake_cmd),
        .i_run_valid     (run_valid),
        .i_run_id        (run_id),
        .i_query_dep     (cmd_q.dep),
        .o_query_pending (query_pending),
        .o_wake_hit      (wake_hit),
        .o_wake_idx      (wake_idx),
        .o_free_idx      (free_idx),
        .o_count         (park_count)
    );

    assign free_vec = ~i_busy_proc;
    assign any_free = |free_vec;
    assign fin_any  = |i_finish_proc;
    assign free_p   = PROC_W'(find_first_set_bit(32'(free_vec)));
    assign fin_p    = PROC_W'(find_first_set_bit(32'(i_finish_proc)));
    assign o_idle   = (state == IDLE) && (run_valid == '0) && (park_count == '0);

    always_comb begin
        state_d     = state;
        o_cmd_ready = 1'b0;
        o_en_proc   = '0;
        o_ack_proc  = '0;
        o_instr     = '0;
        park_wr     = 1'b0;
        park_rd     = 1'b0;
        case (state)
            IDLE: begin
                if (fin_any) begin
                    state_d = FINISH;
                end else if (wake_hit && any_free) begin
                    park_rd = 1'b1;
                    state_d = SEL;
                end else if (i_cmd_valid && any_free && park_count < CNT_W'(PARK_DEPTH)) begin
                    o_cmd_ready = 1'b1;
                    state_d     = CHECK;
                end
            end
            CHECK:  state_d = query_pending ? PARK : SEL;
            PARK: begin
                park_wr = 1'b1;
                state_d = IDLE;
            end
            SEL: begin
                o_en_proc = PROC_COUNT'(1) << free_p;
                state_d   = LD0;
            end
            LD0: begin
                o_ack_proc = PROC_COUNT'(1) << proc_q;
                o_instr    = '{opcode: INSTR_LD, payload: cmd_q.info.addr_0};
                state_d    = LD1;
            end
            LD1: begin
                o_ack_proc = PROC_COUNT'(1) << proc_q;
                o_instr    = '{opcode: INSTR_LD, payload: cmd_q.info.addr_1};
                state_d    = INFO;
            end
            INFO: begin
                o_ack_proc = PROC_COUNT'(1) << proc_q;
                o_instr    = '{opcode: INSTR_INFO, payload: {cmd_q.info.count, cmd_q.info.op, 4'h0}};
                state_d    = STORE;
            end
            STORE: begin
                o_ack_proc = PROC_COUNT'(1) << proc_q;
                o_instr    = '{opcode: INSTR_STORE, payload: cmd_q.info.wr_addr};
                state_d    = IDLE;
            end
            FINISH: begin
                o_ack_proc = PROC_COUNT'(1) << fin_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= IDLE;
            cmd_q          <= '0;
            proc_q         <= '0;
            fin_q          <= '0;
            run_valid      <= '0;
            run_id         <= '0;
            o_err_spurious <= 1'b0;
        end else begin
            state <= state_d;
            if (state == IDLE) begin
                fin_q <= fin_p;
                if (o_cmd_ready) cmd_q <= i_cmd;
                else if (park_rd) cmd_q <= wake_cmd;
            end
            if (state == SEL) begin
                proc_q            <= free_p;
                run_valid[free_p] <= 1'b1;
                run_id[free_p]    <= cmd_q.id;
            end
            if (state == FINISH) begin
                run_valid[fin_q] <= 1'b0;
                if (!run_valid[fin_q]) o_err_spurious <= 1'b1;
            end
        end
    end

    // Free procs are only promised, not reserved, between IDLE and SEL.
    assert property (@(posedge i_clk) disable iff (i_rst) (state == SEL) |-> any_free);

`ifdef ISSUER_PERF_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_perf_issued <= '0;
            o_perf_parked <= '0;
            o_perf_stall  <= '0;
        end else begin
            if (state == SEL && o_perf_issued != '1) o_perf_issued <= o_perf_issued + 32'd1;
            if (state == PARK && o_perf_parked != '1) o_perf_parked <= o_perf_parked + 32'd1;
            if (i_cmd_valid && !o_cmd_ready && o_perf_stall != '1) o_perf_stall <= o_perf_stall + 32'd1;
        end
    end
`endif

endmodule
